// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, receiver FSM states and a bit-vote helper.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one tick every baud_div_i+1 clocks, restartable by clear_i.
module uart_baud_tick (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic [15:0] baud_div_i,
    output logic        tick_o
);

    logic [15:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == 16'd0) && !clear_i;

    always_comb begin
        cnt_d = cnt_q - 16'd1;
        if (clear_i || (cnt_q == 16'd0)) begin
            cnt_d = baud_div_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with majority-vote sampling, parity/stop checks,
// break detection and a single-entry valid/ready holding register.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = PAR_NONE,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [15:0]          BaudDiv,
    input  logic                 Rx,
    output logic [DATA_BITS-1:0] RxData,
    output logic                 RxValid,
    input  logic                 RxReady,
    output logic                 FrameError,
    output logic                 ParityError,
    output logic                 Overrun,
    output logic                 Busy
);

    localparam int unsigned SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] SmpA   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SmpB   = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] SmpC   = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] SmpEnd = SW'(OVERSAMPLE - 1);

    state_e               state_q, state_d;
    logic [1:0]           sync_q, sync_d;
    logic [SW-1:0]        scnt_q, scnt_d;
    logic [3:0]           bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic [1:0]           smp_q, smp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic                 par_q, par_d, perr_q, perr_d, ferr_q, ferr_d, zstop_q, zstop_d;
    logic                 valid_q, valid_d, fe_q, fe_d, pe_q, pe_d, ovr_q, ovr_d;
    logic                 rx_s, tick, restart, vote, mid, bend, done, fe_now, zs_now;

    assign rx_s    = sync_q[1];
    assign restart = (state_q == StIdle) && !rx_s;
    assign vote    = maj3(smp_q[1], smp_q[0], rx_s);
    assign mid     = tick && (scnt_q == SmpC);
    assign bend    = tick && (scnt_q == SmpEnd);

    uart_baud_tick u_tick (
        .clk_i      (Clock),
        .rst_i      (Reset),
        .clear_i    (restart),
        .baud_div_i (BaudDiv),
        .tick_o     (tick)
    );

    always_comb begin
        state_d = state_q;
        sync_d  = {sync_q[0], Rx};
        scnt_d  = scnt_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        smp_d   = smp_q;
        shift_d = shift_q;
        par_d   = par_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        zstop_d = zstop_q;
        data_d  = data_q;
        valid_d = valid_q;
        fe_d    = fe_q;
        pe_d    = pe_q;
        ovr_d   = ovr_q;
        done    = 1'b0;
        fe_now  = ferr_q | ~vote;
        zs_now  = zstop_q & ~vote;

        if (tick && (state_q != StIdle) && (state_q != StBreak)) begin
            scnt_d = (scnt_q == SmpEnd) ? '0 : scnt_q + SW'(1);
            if (scnt_q == SmpA) smp_d[1] = rx_s;
            if (scnt_q == SmpB) smp_d[0] = rx_s;
        end

        unique case (state_q)
            StIdle: begin
                if (restart) begin
                    state_d = StStart;
                    scnt_d  = '0;
                    bit_d   = 4'd0;
                    stop_d  = 1'b0;
                    par_d   = 1'b0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                    zstop_d = 1'b1;
                end
            end
            StStart: begin
                if (mid && vote) state_d = StIdle;
                else if (bend)   state_d = StData;
            end
            StData: begin
                if (mid) begin
                    shift_d = {vote, shift_q[DATA_BITS-1:1]};
                    par_d   = par_q ^ vote;
                end
                if (bend) begin
                    if (bit_q == 4'(DATA_BITS - 1)) begin
                        state_d = (PARITY != PAR_NONE) ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            StParity: begin
                if (mid)  perr_d  = (par_q ^ vote) != (PARITY == PAR_ODD);
                if (bend) state_d = StStop;
            end
            StStop: begin
                // The frame completes at the mid-bit vote of the last stop bit.
                if (mid) begin
                    ferr_d  = fe_now;
                    zstop_d = zs_now;
                    if (stop_q == 1'(STOP_BITS - 1)) begin
                        done    = 1'b1;
                        state_d = (zs_now && (shift_q == '0)) ? StBreak : StIdle;
                    end
                end
                if (bend) stop_d = 1'b1;
            end
            StBreak: begin
                if (rx_s) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (valid_q && RxReady) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
        if (done) begin
            if (!valid_q || RxReady) begin
                data_d  = shift_q;
                fe_d    = fe_now;
                pe_d    = perr_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            sync_q  <= 2'b11;
            scnt_q  <= '0;
            bit_q   <= 4'd0;
            stop_q  <= 1'b0;
            smp_q   <= 2'b00;
            shift_q <= '0;
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            zstop_q <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            scnt_q  <= scnt_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            smp_q   <= smp_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            zstop_q <= zstop_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            pe_q    <= pe_d;
            ovr_q   <= ovr_d;
        end
    end

    assign RxData      = data_q;
    assign RxValid     = valid_q;
    assign FrameError  = fe_q;
    assign ParityError = pe_q;
    assign Overrun     = ovr_q;
    assign Busy        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: three configurations (8N1, 8E1, 8N2) driven by a serial
// frame generator, checked against an expected-frame queue built from the sent bits.
module tb_uart_rx_os;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] div  [3];
    logic        rx   [3];
    logic        rdy  [3];
    logic        vld  [3];
    logic        fe   [3];
    logic        pe   [3];
    logic        ovr  [3];
    logic        busy [3];
    logic [7:0]  rxd  [3];

    always #5 clk = ~clk;

    uart_rx_os u_n1 (
        .Clock(clk), .Reset(rst), .BaudDiv(div[0]), .Rx(rx[0]), .RxData(rxd[0]),
        .RxValid(vld[0]), .RxReady(rdy[0]), .FrameError(fe[0]), .ParityError(pe[0]),
        .Overrun(ovr[0]), .Busy(busy[0])
    );
    uart_rx_os #(.PARITY(2)) u_e1 (
        .Clock(clk), .Reset(rst), .BaudDiv(div[1]), .Rx(rx[1]), .RxData(rxd[1]),
        .RxValid(vld[1]), .RxReady(rdy[1]), .FrameError(fe[1]), .ParityError(pe[1]),
        .Overrun(ovr[1]), .Busy(busy[1])
    );
    uart_rx_os #(.STOP_BITS(2)) u_n2 (
        .Clock(clk), .Reset(rst), .BaudDiv(div[2]), .Rx(rx[2]), .RxData(rxd[2]),
        .RxValid(vld[2]), .RxReady(rdy[2]), .FrameError(fe[2]), .ParityError(pe[2]),
        .Overrun(ovr[2]), .Busy(busy[2])
    );

    typedef struct {
        int         inst;
        logic [7:0] data;
        logic       fe;
        logic       pe;
    } exp_t;

    exp_t       eq[$];
    int         checks = 0;
    int         errors = 0;
    int         vcnt [3] = '{0, 0, 0};
    logic       vprev [3] = '{1'b0, 1'b0, 1'b0};
    logic [7:0] last_d [3];
    logic       last_fe [3];
    logic       last_pe [3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic int find(input int i);
        foreach (eq[k]) if (eq[k].inst == i) return k;
        return -1;
    endfunction

    function automatic int pending(input int i);
        int n = 0;
        foreach (eq[k]) if (eq[k].inst == i) n++;
        return n;
    endfunction

    function automatic int bit_clks(input int i);
        return 16 * (int'(div[i]) + 1);
    endfunction

    // Every cycle a frame is held, it must match the oldest outstanding frame for that receiver.
    always @(negedge clk) begin
        int k;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                vprev[i] = 1'b0;
            end else begin
                if (vld[i] && !vprev[i]) vcnt[i]++;
                vprev[i] = vld[i];
                if (vld[i]) begin
                    k = find(i);
                    if (k < 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_valid[%0d]: RxValid=1 data=%0h, no frame expected",
                                 i, rxd[i]);
                    end else begin
                        chk($sformatf("rx_data[%0d]", i), 32'(rxd[i]), 32'(eq[k].data));
                        chk($sformatf("frame_err[%0d]", i), 32'(fe[i]), 32'(eq[k].fe));
                        chk($sformatf("parity_err[%0d]", i), 32'(pe[i]), 32'(eq[k].pe));
                        last_d[i]  = rxd[i];
                        last_fe[i] = fe[i];
                        last_pe[i] = pe[i];
                        if (rdy[i]) eq.delete(k);
                    end
                end
            end
        end
    end

    task automatic drive(input int i, input logic v, input int n);
        rx[i] = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int i, input logic [7:0] d, input int pmode, input logic pbit,
                        input int nstop, input logic [1:0] stops, input int bclk,
                        input bit expect_it);
        exp_t e;
        if (expect_it) begin
            e.inst = i;
            e.data = d;
            e.fe   = !stops[0] || (nstop == 2 && !stops[1]);
            e.pe   = (pmode != 0) && ((^d ^ pbit) != (pmode == 1));
            eq.push_back(e);
        end
        drive(i, 1'b0, bclk);
        for (int b = 0; b < 8; b++) drive(i, d[b], bclk);
        if (pmode != 0) drive(i, pbit, bclk);
        for (int s = 0; s < nstop; s++) drive(i, stops[s], bclk);
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_data[%0d]", tag, i), 32'(rxd[i]), 32'd0);
            chk($sformatf("%s_valid[%0d]", tag, i), 32'(vld[i]), 32'd0);
            chk($sformatf("%s_ferr[%0d]", tag, i), 32'(fe[i]), 32'd0);
            chk($sformatf("%s_perr[%0d]", tag, i), 32'(pe[i]), 32'd0);
            chk($sformatf("%s_ovr[%0d]", tag, i), 32'(ovr[i]), 32'd0);
            chk($sformatf("%s_busy[%0d]", tag, i), 32'(busy[i]), 32'd0);
        end
    endtask

    initial begin
        int v0, bc, gap;
        logic [7:0] d;
        logic bad, pb;

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rx[i]  = 1'b1;
            rdy[i] = 1'b1;
        end
        div[0] = 16'd26;
        div[1] = 16'd3;
        div[2] = 16'd3;
        repeat (5) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // 8N1 at BaudDiv=26: a single clean 0x55.
        v0 = vcnt[0];
        send(0, 8'h55, 0, 1'b0, 1, 2'b11, bit_clks(0), 1'b1);
        drive(0, 1'b1, 2 * bit_clks(0));
        chk("n1_pulses", 32'(vcnt[0] - v0), 32'd1);
        chk("n1_data_55", 32'(last_d[0]), 32'h55);
        chk("n1_ferr_55", 32'(last_fe[0]), 32'd0);
        chk("n1_ovr_55", 32'(ovr[0]), 32'd0);
        chk("n1_drained", 32'(pending(0)), 32'd0);

        // Even parity: 0xA3 has four ones, so a parity bit of 1 is wrong and 0 is right.
        send(1, 8'hA3, 2, 1'b1, 1, 2'b11, bit_clks(1), 1'b1);
        drive(1, 1'b1, 2 * bit_clks(1));
        chk("e1_perr_bad", 32'(last_pe[1]), 32'd1);
        chk("e1_data_bad", 32'(last_d[1]), 32'hA3);
        send(1, 8'hA3, 2, 1'b0, 1, 2'b11, bit_clks(1), 1'b1);
        drive(1, 1'b1, 2 * bit_clks(1));
        chk("e1_perr_good", 32'(last_pe[1]), 32'd0);
        chk("e1_drained", 32'(pending(1)), 32'd0);

        // 0x96 x10 back to back, sender 3% slow, then 3% fast.
        div[0] = 16'd7;
        v0 = vcnt[0];
        for (int r = 0; r < 2; r++) begin
            bc = (r == 0) ? 132 : 124;
            for (int n = 0; n < 10; n++) send(0, 8'h96, 0, 1'b0, 1, 2'b11, bc, 1'b1);
            drive(0, 1'b1, 2 * bit_clks(0));
        end
        chk("skew_frames", 32'(vcnt[0] - v0), 32'd20);
        chk("skew_drained", 32'(pending(0)), 32'd0);

        // Overrun: 0x22 is dropped while 0x11 is held.
        div[0] = 16'd3;
        rdy[0] = 1'b0;
        send(0, 8'h11, 0, 1'b0, 1, 2'b11, bit_clks(0), 1'b1);
        send(0, 8'h22, 0, 1'b0, 1, 2'b11, bit_clks(0), 1'b0);
        drive(0, 1'b1, bit_clks(0));
        chk("ovr_set", 32'(ovr[0]), 32'd1);
        chk("ovr_held_valid", 32'(vld[0]), 32'd1);
        chk("ovr_held_data", 32'(rxd[0]), 32'h11);
        rdy[0] = 1'b1;
        @(posedge clk);
        #1;
        rdy[0] = 1'b0;
        chk("ovr_valid_after", 32'(vld[0]), 32'd0);
        chk("ovr_clear_after", 32'(ovr[0]), 32'd0);
        rdy[0] = 1'b1;

        // Half-bit glitch is a false start.
        v0 = vcnt[0];
        drive(0, 1'b0, 10);
        chk("glitch_busy", 32'(busy[0]), 32'd1);
        drive(0, 1'b0, 22);
        drive(0, 1'b1, 2 * bit_clks(0));
        chk("glitch_idle", 32'(busy[0]), 32'd0);
        chk("glitch_no_frame", 32'(vcnt[0] - v0), 32'd0);

        // Break: delivered once as 0x00 with FrameError, then no restart while low.
        eq.push_back('{inst: 0, data: 8'h00, fe: 1'b1, pe: 1'b0});
        drive(0, 1'b0, 12 * bit_clks(0));
        chk("break_busy", 32'(busy[0]), 32'd1);
        drive(0, 1'b0, 8 * bit_clks(0));
        chk("break_still_busy", 32'(busy[0]), 32'd1);
        chk("break_frames", 32'(vcnt[0] - v0), 32'd1);
        chk("break_data", 32'(last_d[0]), 32'h00);
        chk("break_ferr", 32'(last_fe[0]), 32'd1);
        drive(0, 1'b1, 2 * bit_clks(0));
        chk("break_released", 32'(busy[0]), 32'd0);
        send(0, 8'h3C, 0, 1'b0, 1, 2'b11, bit_clks(0), 1'b1);
        drive(0, 1'b1, 2 * bit_clks(0));
        chk("after_break_data", 32'(last_d[0]), 32'h3C);
        chk("after_break_ferr", 32'(last_fe[0]), 32'd0);

        // Two stop bits, second one low.
        send(2, 8'h5A, 0, 1'b0, 2, 2'b01, bit_clks(2), 1'b1);
        drive(2, 1'b1, 2 * bit_clks(2));
        chk("stop2_ferr", 32'(last_fe[2]), 32'd1);
        chk("stop2_data", 32'(last_d[2]), 32'h5A);

        // Load state everywhere, then reset in the middle of a data bit.
        rdy[0] = 1'b0;
        send(0, 8'h7E, 0, 1'b0, 1, 2'b11, bit_clks(0), 1'b1);
        send(0, 8'h81, 0, 1'b0, 1, 2'b11, bit_clks(0), 1'b0);
        drive(0, 1'b1, bit_clks(0));
        chk("pre_reset_valid", 32'(vld[0]), 32'd1);
        chk("pre_reset_ovr", 32'(ovr[0]), 32'd1);
        drive(2, 1'b0, 4 * bit_clks(2));
        drive(2, 1'b0, bit_clks(2) / 2);
        chk("pre_reset_busy", 32'(busy[2]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        eq.delete();
        for (int i = 0; i < 3; i++) begin
            rx[i]  = 1'b1;
            rdy[i] = 1'b1;
        end
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        drive(2, 1'b1, 2 * bit_clks(2));
        chk("post_reset_idle", 32'(busy[2]), 32'd0);
        send(2, 8'hC3, 0, 1'b0, 2, 2'b11, bit_clks(2), 1'b1);
        drive(2, 1'b1, 2 * bit_clks(2));
        chk("post_reset_data", 32'(last_d[2]), 32'hC3);
        chk("post_reset_ferr", 32'(last_fe[2]), 32'd0);

        // Random 8N1 frames with +-3% skew and occasional bad stop bits.
        for (int n = 0; n < 16; n++) begin
            d   = 8'($urandom);
            bc  = bit_clks(0) + 2 * (int'($urandom_range(0, 2)) - 1);
            bad = ($urandom_range(0, 7) == 0);
            send(0, d, 0, 1'b0, 1, bad ? 2'b10 : 2'b11, bc, 1'b1);
            gap = int'($urandom_range(0, 1)) + (bad ? 1 : 0);
            if (gap != 0) drive(0, 1'b1, gap * bit_clks(0));
        end
        drive(0, 1'b1, 2 * bit_clks(0));
        chk("rand_n1_drained", 32'(pending(0)), 32'd0);

        // Random 8E1 frames with random parity bits.
        for (int n = 0; n < 10; n++) begin
            d  = 8'($urandom);
            pb = 1'($urandom);
            send(1, d, 2, pb, 1, 2'b11, bit_clks(1), 1'b1);
            if ($urandom_range(0, 1) == 1) drive(1, 1'b1, bit_clks(1));
        end
        drive(1, 1'b1, 2 * bit_clks(1));
        chk("rand_e1_drained", 32'(pending(1)), 32'd0);
        chk("all_drained", 32'(eq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
